// File: rtl/tracker_pkg.sv
// ---------------------------------------------------------------------------
// tracker_pkg
// Shared types and default widths for the tracking datapath.
//   peak_state_t : pass FSM states used by peak_select (IDLE/SEARCH/PUBLISH)
//   COORD_W_DEF  : default template coordinate width (x 0..639, y 0..479)
//   SCORE_W_DEF  : default SAD score width (lower is better)
// ---------------------------------------------------------------------------
package tracker_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int SCORE_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    PUBLISH = 2'd2
  } peak_state_t;

endpackage

// File: rtl/axis_smoother.sv
// ---------------------------------------------------------------------------
// axis_smoother
// One exponential-moving-average step for a single axis (combinational).
//   i_cur  : currently published coordinate
//   i_best : raw winning coordinate of the pass just finished
//   i_en   : 1 = take a smoothed step toward i_best, 0 = jump to i_best
//   o_next : coordinate to publish
// The step is cur + ((best - cur) >>> SHIFT). The difference is formed one
// bit wider and signed; the arithmetic shift rounds toward minus infinity, so
// the result always lies between cur and best and fits in COORD_W bits.
// ---------------------------------------------------------------------------
module axis_smoother
  import tracker_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int SHIFT   = 2
) (
  input  logic [COORD_W-1:0] i_cur,
  input  logic [COORD_W-1:0] i_best,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_next
);

  logic signed [COORD_W:0] w_diff;
  logic signed [COORD_W:0] w_step;
  logic [COORD_W-1:0]      w_sum;

  assign w_diff = $signed({1'b0, i_best}) - $signed({1'b0, i_cur});
  assign w_step = w_diff >>> SHIFT;
  // Modular add; the true result is in range so dropping the top bit is exact.
  assign w_sum  = COORD_W'($unsigned(w_step) + {1'b0, i_cur});

  assign o_next = i_en ? w_sum : i_best;

endmodule

// File: rtl/peak_select.sv
// ---------------------------------------------------------------------------
// peak_select
// Per-pass minimum-SAD finder and template position publisher.
//   clk, rst_n          : clock, asynchronous active-low reset
//   tracking_mode       : tracking enabled; low forces IDLE and drops lock
//   smooth_mode         : 1 = EMA-smooth published position once locked
//   frame_start         : pulse, a new search pass begins (restarts in SEARCH)
//   score_valid, score, score_x, score_y : candidate stream, one per cycle
//   frame_done          : pulse, the last score of the pass has been sent
//   max_x, max_y        : published template top-left
//   max_ready           : one-cycle pulse, new publication (hit or miss)
//   best_score          : winning score of the last completed pass
//   lost                : consecutive misses reached MISS_LIMIT
//   dbg_state           : current pass FSM state
// Handshake: the score stream has no back-pressure; a candidate is consumed
// in every cycle where score_valid is high and the FSM is in SEARCH, and is
// ignored in any other state.
// ---------------------------------------------------------------------------
module peak_select
  import tracker_pkg::*;
#(
  parameter int          COORD_W      = COORD_W_DEF,
  parameter int          SCORE_W      = SCORE_W_DEF,
  parameter int          SMOOTH_SHIFT = 2,
  parameter int unsigned SCORE_THRESH = 32'h2000,
  parameter int          MISS_LIMIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tracking_mode,
  input  logic               smooth_mode,
  input  logic               frame_start,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [COORD_W-1:0] score_x,
  input  logic [COORD_W-1:0] score_y,
  input  logic               frame_done,
  output logic [COORD_W-1:0] max_x,
  output logic [COORD_W-1:0] max_y,
  output logic               max_ready,
  output logic [SCORE_W-1:0] best_score,
  output logic               lost,
  output peak_state_t        dbg_state
);

  localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

  peak_state_t        r_state;
  peak_state_t        w_next_state;

  logic [SCORE_W-1:0] r_cur_best;
  logic               r_seen;
  logic [COORD_W-1:0] r_bx;
  logic [COORD_W-1:0] r_by;
  logic [COORD_W-1:0] r_max_x;
  logic [COORD_W-1:0] r_max_y;
  logic               r_max_ready;
  logic [SCORE_W-1:0] r_best_score;
  logic               r_lost;
  logic               r_locked;
  logic [3:0]         r_miss;

  logic               w_hit;
  logic               w_smooth_en;
  logic               w_better;
  logic [3:0]         w_miss_inc;
  logic [COORD_W-1:0] w_next_x;
  logic [COORD_W-1:0] w_next_y;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!tracking_mode) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (frame_start) w_next_state = SEARCH;
        // A restart takes priority over ending the pass in the same cycle.
        SEARCH:  if (!frame_start && frame_done) w_next_state = PUBLISH;
        PUBLISH: w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // ---------------- comparator / publish decisions ----------------
  // Strict compare: on equal scores the earlier candidate is kept.
  assign w_better    = score_valid && (score < r_cur_best);
  assign w_hit       = r_seen && (32'(r_cur_best) <= SCORE_THRESH);
  assign w_smooth_en = r_locked && smooth_mode;
  assign w_miss_inc  = (r_miss < MISS_MAX) ? (r_miss + 4'd1) : r_miss;

  axis_smoother #(.COORD_W(COORD_W), .SHIFT(SMOOTH_SHIFT)) u_smooth_x (
    .i_cur  (r_max_x),
    .i_best (r_bx),
    .i_en   (w_smooth_en),
    .o_next (w_next_x)
  );

  axis_smoother #(.COORD_W(COORD_W), .SHIFT(SMOOTH_SHIFT)) u_smooth_y (
    .i_cur  (r_max_y),
    .i_best (r_by),
    .i_en   (w_smooth_en),
    .o_next (w_next_y)
  );

  // ---------------- datapath / output registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_best   <= '1;
      r_seen       <= 1'b0;
      r_bx         <= '0;
      r_by         <= '0;
      r_max_x      <= '0;
      r_max_y      <= '0;
      r_max_ready  <= 1'b0;
      r_best_score <= '1;
      r_lost       <= 1'b0;
      r_locked     <= 1'b0;
      r_miss       <= 4'd0;
    end else begin
      r_max_ready <= 1'b0;
      if (!tracking_mode) begin
        // Lock and miss history are dropped; positions and best_score hold.
        r_locked   <= 1'b0;
        r_miss     <= 4'd0;
        r_lost     <= 1'b0;
        r_cur_best <= '1;
        r_seen     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cur_best <= '1;
            r_seen     <= 1'b0;
          end
          SEARCH: begin
            if (frame_start) begin
              r_cur_best <= '1;
              r_seen     <= 1'b0;
            end else if (w_better) begin
              r_cur_best <= score;
              r_bx       <= score_x;
              r_by       <= score_y;
              r_seen     <= 1'b1;
            end
          end
          PUBLISH: begin
            r_best_score <= r_cur_best;
            r_max_ready  <= 1'b1;
            if (w_hit) begin
              r_miss   <= 4'd0;
              r_lost   <= 1'b0;
              r_locked <= 1'b1;
              r_max_x  <= w_next_x;
              r_max_y  <= w_next_y;
            end else begin
              r_miss <= w_miss_inc;
              r_lost <= (w_miss_inc == MISS_MAX);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign max_x      = r_max_x;
  assign max_y      = r_max_y;
  assign max_ready  = r_max_ready;
  assign best_score = r_best_score;
  assign lost       = r_lost;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_peak_select.sv
module tb_peak_select;
  import tracker_pkg::*;

  localparam int CW     = 10;
  localparam int SW     = 16;
  localparam int SHIFT  = 2;
  localparam int THRESH = 'h2000;
  localparam int LIMIT  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          tracking_mode = 1'b0;
  logic          smooth_mode = 1'b0;
  logic          frame_start = 1'b0;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score = '0;
  logic [CW-1:0] score_x = '0;
  logic [CW-1:0] score_y = '0;
  logic          frame_done = 1'b0;
  logic [CW-1:0] max_x;
  logic [CW-1:0] max_y;
  logic          max_ready;
  logic [SW-1:0] best_score;
  logic          lost;
  peak_state_t   dbg_state;

  peak_select dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tracking_mode (tracking_mode),
    .smooth_mode   (smooth_mode),
    .frame_start   (frame_start),
    .score_valid   (score_valid),
    .score         (score),
    .score_x       (score_x),
    .score_y       (score_y),
    .frame_done    (frame_done),
    .max_x         (max_x),
    .max_y         (max_y),
    .max_ready     (max_ready),
    .best_score    (best_score),
    .lost          (lost),
    .dbg_state     (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef struct { int s; int x; int y; } cand_t;
  cand_t pass_q[$];

  int m_x = 0, m_y = 0, m_best = 'hFFFF, m_miss = 0;
  bit m_locked = 0, m_lost = 0;

  function automatic int fdiv(input int d);
    int den = 1 << SHIFT;
    if (d >= 0) return d / den;
    return -((-d + den - 1) / den);
  endfunction

  // Applies the publication rules to the candidates held in pass_q.
  function automatic void model_pass(input bit smooth);
    int  best = 'hFFFF;
    int  bx = 0, by = 0;
    bit  seen = 0;
    foreach (pass_q[i]) begin
      if (pass_q[i].s < best) begin
        best = pass_q[i].s; bx = pass_q[i].x; by = pass_q[i].y; seen = 1;
      end
    end
    m_best = best;
    if (seen && best <= THRESH) begin
      m_miss = 0;
      m_lost = 0;
      if (!m_locked || !smooth) begin
        m_x = bx; m_y = by; m_locked = 1;
      end else begin
        m_x = m_x + fdiv(bx - m_x);
        m_y = m_y + fdiv(by - m_y);
      end
    end else begin
      if (m_miss < LIMIT) m_miss++;
      m_lost = (m_miss == LIMIT);
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic          o_r0, o_r1, o_r2, o_lost;
  logic [CW-1:0] o_x, o_y;
  logic [SW-1:0] o_best;

  // Runs one pass from pass_q; samples max_ready after the frame_done edge (N),
  // N+1 and N+2, and the published outputs after N+1.
  task automatic run_pass(input bit done_with_last, input int gap_pct);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    foreach (pass_q[i]) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        score_valid = 1'b0;
        tick();
      end
      score_valid = 1'b1;
      score       = SW'(pass_q[i].s);
      score_x     = CW'(pass_q[i].x);
      score_y     = CW'(pass_q[i].y);
      frame_done  = done_with_last && (i == pass_q.size() - 1);
      tick();
    end
    score_valid = 1'b0;
    if (!frame_done) begin
      frame_done = 1'b1;
      tick();
    end
    frame_done = 1'b0;
    o_r0 = max_ready;
    tick();
    o_r1 = max_ready; o_x = max_x; o_y = max_y; o_best = best_score; o_lost = lost;
    tick();
    o_r2 = max_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (max_x !== '0) begin failures++; $display("FAIL reset_max_x got=%0d exp=0", max_x); end
    checks++; if (max_y !== '0) begin failures++; $display("FAIL reset_max_y got=%0d exp=0", max_y); end
    checks++; if (max_ready !== 1'b0) begin failures++; $display("FAIL reset_max_ready got=%b exp=0", max_ready); end
    checks++; if (best_score !== 16'hFFFF) begin failures++; $display("FAIL reset_best_score got=%h exp=ffff", best_score); end
    checks++; if (lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", lost); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_basic();
    tracking_mode = 1'b1; smooth_mode = 1'b1;
    pass_q = '{'{100, 10, 20}, '{50, 30, 40}, '{50, 5, 5}};
    run_pass(1'b0, 0);
    model_pass(1'b1);
    checks++; if (o_r0 !== 1'b0) begin failures++; $display("FAIL basic_ready_n1 got=%b exp=0", o_r0); end
    checks++; if (o_r1 !== 1'b1) begin failures++; $display("FAIL basic_ready_n2 got=%b exp=1", o_r1); end
    checks++; if (o_r2 !== 1'b0) begin failures++; $display("FAIL basic_ready_n3 got=%b exp=0", o_r2); end
    checks++; if (o_x !== 10'd30 || o_y !== 10'd40) begin failures++; $display("FAIL basic_pos got=%0d,%0d exp=30,40", o_x, o_y); end
    checks++; if (o_best !== 16'd50) begin failures++; $display("FAIL basic_best got=%0d exp=50", o_best); end
  endtask

  task automatic test_smooth();
    smooth_mode = 1'b0;
    pass_q = '{'{100, 100, 100}};
    run_pass(1'b0, 0); model_pass(1'b0);
    smooth_mode = 1'b1;
    pass_q = '{'{200, 140, 60}};
    run_pass(1'b0, 0); model_pass(1'b1);
    checks++; if (o_x !== 10'd110 || o_y !== 10'd90) begin failures++; $display("FAIL smooth_on got=%0d,%0d exp=110,90", o_x, o_y); end
    checks++; if (o_x !== CW'(m_x) || o_y !== CW'(m_y)) begin failures++; $display("FAIL smooth_model got=%0d,%0d exp=%0d,%0d", o_x, o_y, m_x, m_y); end
    smooth_mode = 1'b0;
    pass_q = '{'{100, 100, 100}};
    run_pass(1'b0, 0); model_pass(1'b0);
    pass_q = '{'{200, 140, 60}};
    run_pass(1'b0, 0); model_pass(1'b0);
    checks++; if (o_x !== 10'd140 || o_y !== 10'd60) begin failures++; $display("FAIL smooth_off got=%0d,%0d exp=140,60", o_x, o_y); end
  endtask

  task automatic test_miss();
    smooth_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pass_q = '{'{'h3000, 10 + k, 11}, '{'h3000, 20, 21 + k}, '{'h3000, 30, 31}};
      run_pass(1'b0, 0); model_pass(1'b1);
      checks++; if (o_r1 !== 1'b1) begin failures++; $display("FAIL miss_ready[%0d] got=%b exp=1", k, o_r1); end
      checks++; if (o_lost !== (k == 3)) begin failures++; $display("FAIL miss_lost[%0d] got=%b exp=%b", k, o_lost, (k == 3)); end
      checks++; if (o_x !== CW'(m_x) || o_y !== CW'(m_y)) begin failures++; $display("FAIL miss_hold[%0d] got=%0d,%0d exp=%0d,%0d", k, o_x, o_y, m_x, m_y); end
      checks++; if (o_best !== 16'h3000) begin failures++; $display("FAIL miss_best[%0d] got=%h exp=3000", k, o_best); end
    end
    pass_q = '{'{300, 50, 60}};
    smooth_mode = 1'b0;
    run_pass(1'b0, 0); model_pass(1'b0);
    checks++; if (o_lost !== 1'b0) begin failures++; $display("FAIL miss_recover_lost got=%b exp=0", o_lost); end
    checks++; if (o_x !== 10'd50 || o_y !== 10'd60) begin failures++; $display("FAIL miss_recover_pos got=%0d,%0d exp=50,60", o_x, o_y); end
  endtask

  task automatic test_same_cycle();
    smooth_mode = 1'b0;
    pass_q = '{'{20, 1, 1}, '{10, 2, 2}, '{1, 7, 9}};
    run_pass(1'b1, 0); model_pass(1'b0);
    checks++; if (o_x !== 10'd7 || o_y !== 10'd9) begin failures++; $display("FAIL same_cycle_pos got=%0d,%0d exp=7,9", o_x, o_y); end
    checks++; if (o_best !== 16'd1) begin failures++; $display("FAIL same_cycle_best got=%0d exp=1", o_best); end
    checks++; if (o_r0 !== 1'b0 || o_r1 !== 1'b1 || o_r2 !== 1'b0) begin failures++; $display("FAIL same_cycle_ready got=%b%b%b exp=010", o_r0, o_r1, o_r2); end
  endtask

  task automatic test_restart();
    smooth_mode = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    score_valid = 1'b1; score = 16'd30; score_x = 10'd3; score_y = 10'd3; tick();
    score = 16'd5; score_x = 10'd4; score_y = 10'd4; tick();
    score_valid = 1'b0;
    pass_q = '{'{80, 1, 2}};
    run_pass(1'b0, 0); model_pass(1'b0);
    checks++; if (o_x !== 10'd1 || o_y !== 10'd2) begin failures++; $display("FAIL restart_pos got=%0d,%0d exp=1,2", o_x, o_y); end
    checks++; if (o_best !== 16'd80) begin failures++; $display("FAIL restart_best got=%0d exp=80", o_best); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 30; p++) begin
      int n = $urandom_range(1, 8);
      bit sm = 1'($urandom_range(0, 1));
      bit dwl = 1'($urandom_range(0, 1));
      pass_q.delete();
      for (int i = 0; i < n; i++) begin
        cand_t c;
        // Coarse score grid makes ties and the exact threshold value common.
        c.s = ($urandom_range(0, 15) == 0) ? 'hFFFF : $urandom_range(0, 40) * 256;
        c.x = $urandom_range(0, 639);
        c.y = $urandom_range(0, 479);
        pass_q.push_back(c);
      end
      smooth_mode = sm;
      run_pass(dwl, 30); model_pass(sm);
      checks++; if (o_r0 !== 1'b0 || o_r1 !== 1'b1 || o_r2 !== 1'b0) begin failures++; $display("FAIL rand_ready[%0d] got=%b%b%b exp=010", p, o_r0, o_r1, o_r2); end
      checks++; if (o_x !== CW'(m_x) || o_y !== CW'(m_y)) begin failures++; $display("FAIL rand_pos[%0d] got=%0d,%0d exp=%0d,%0d", p, o_x, o_y, m_x, m_y); end
      checks++; if (o_best !== SW'(m_best)) begin failures++; $display("FAIL rand_best[%0d] got=%h exp=%h", p, o_best, m_best); end
      checks++; if (o_lost !== m_lost) begin failures++; $display("FAIL rand_lost[%0d] got=%b exp=%b", p, o_lost, m_lost); end
    end
  endtask

  task automatic test_drop_and_reset();
    bit saw_ready = 0;
    smooth_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pass_q = '{'{'h3000, 1, 1}};
      run_pass(1'b0, 0); model_pass(1'b1);
    end
    checks++; if (lost !== 1'b1) begin failures++; $display("FAIL drop_pre_lost got=%b exp=1", lost); end
    // Drop tracking mid-SEARCH while frame_done is also asserted.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    score_valid = 1'b1; score = 16'd3; score_x = 10'd600; score_y = 10'd400; tick();
    tracking_mode = 1'b0; frame_done = 1'b1; tick();
    score_valid = 1'b0; frame_done = 1'b0;
    m_locked = 0; m_miss = 0; m_lost = 0;
    for (int c = 0; c < 4; c++) begin
      if (max_ready === 1'b1) saw_ready = 1;
      tick();
    end
    checks++; if (saw_ready) begin failures++; $display("FAIL drop_no_ready got=1 exp=0"); end
    checks++; if (lost !== 1'b0) begin failures++; $display("FAIL drop_lost got=%b exp=0", lost); end
    checks++; if (max_x !== CW'(m_x) || max_y !== CW'(m_y)) begin failures++; $display("FAIL drop_hold got=%0d,%0d exp=%0d,%0d", max_x, max_y, m_x, m_y); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL drop_state got=%0d exp=%0d", dbg_state, IDLE); end
    // Lock was dropped: the next hit publishes raw even with smoothing on.
    tracking_mode = 1'b1;
    pass_q = '{'{100, 200, 300}};
    run_pass(1'b0, 0); model_pass(1'b1);
    checks++; if (o_x !== 10'd200 || o_y !== 10'd300) begin failures++; $display("FAIL drop_relock got=%0d,%0d exp=200,300", o_x, o_y); end
    // Asynchronous reset in the middle of a pass.
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    score_valid = 1'b1; score = 16'd7; score_x = 10'd9; score_y = 10'd8; tick();
    score_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (max_x !== '0 || max_y !== '0) begin failures++; $display("FAIL areset_pos got=%0d,%0d exp=0,0", max_x, max_y); end
    checks++; if (best_score !== 16'hFFFF) begin failures++; $display("FAIL areset_best got=%h exp=ffff", best_score); end
    checks++; if (max_ready !== 1'b0 || lost !== 1'b0) begin failures++; $display("FAIL areset_flags got=%b%b exp=00", max_ready, lost); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL areset_state got=%0d exp=%0d", dbg_state, IDLE); end
    frame_done = 1'b1; tick(); frame_done = 1'b0;
    tick();
    checks++; if (max_ready !== 1'b0) begin failures++; $display("FAIL areset_no_ready got=%b exp=0", max_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_smooth();
    test_miss();
    test_same_cycle();
    test_restart();
    test_random();
    test_drop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
